// File: rtl/fetch_predictor_pkg.sv
// Shared types for the fetch-stage branch predictor: table entry layout,
// predictor FSM states and 2-bit counter encodings.
package fetch_predictor_pkg;

    // Widest tag the entry can hold. The stored tag is the PC tag zero-extended
    // to this width, so any IDX_BITS choice fits without a new struct.
    localparam int TAG_MAX = 30;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef enum logic {
        PRED_INIT,
        PRED_READY
    } pred_fsm_t;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic [31:0]        target;
        logic [1:0]         ctr;
    } btb_entry_t;

endpackage

// File: rtl/fetch_predictor_sat_ctr2.sv
// 2-bit saturating up/down counter step, purely combinational.
module sat_ctr2
    import fetch_predictor_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       inc_i,
    output logic [1:0] ctr_o
);

    // Step toward taken on inc, toward not-taken otherwise; hold at the rails.
    always_comb begin
        ctr_o = ctr_i;
        if (inc_i) begin
            if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/fetch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with 2-bit counters.
// Lookup is combinational on if_pc; EX resolutions update the table at the
// clock edge and raise a combinational redirect on mispredict. After reset
// the table is cleared one entry per cycle before predictions are used.
module fetch_predictor
    import fetch_predictor_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic [31:0] next_pc,
    output logic        pred_taken,
    output logic [1:0]  pred_state,
    output logic [31:0] pred_target,
    output logic        init_busy,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        ex_mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] mispredict_cnt
);

    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int ENTRIES  = 1 << IDX_BITS;

    pred_fsm_t           state_q, state_d;
    logic [IDX_BITS-1:0] clear_idx_q, clear_idx_d;
    logic [31:0]         mp_cnt_q;
    btb_entry_t          btb_q [ENTRIES];

    logic                ready;
    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_MAX-1:0]  if_tag, ex_tag;
    btb_entry_t          lk_e, up_e, up_new;
    logic                lk_hit, up_hit, up_we, mispredict;
    logic [1:0]          ctr_step;
    logic                unused_pc_bits;

    assign ready  = (state_q == PRED_READY);
    assign if_idx = if_pc[IDX_BITS+1:2];
    assign ex_idx = ex_pc[IDX_BITS+1:2];
    assign if_tag = {{IDX_BITS{1'b0}}, if_pc[31:IDX_BITS+2]};
    assign ex_tag = {{IDX_BITS{1'b0}}, ex_pc[31:IDX_BITS+2]};
    // Instructions are word aligned; the byte-offset bits carry no information.
    assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

    // Fetch-side lookup; table contents are ignored until the clear walk ends.
    always_comb begin
        lk_e        = btb_q[if_idx];
        lk_hit      = ready && lk_e.valid && (lk_e.tag == if_tag);
        pred_state  = lk_hit ? lk_e.ctr : CTR_WNT;
        pred_target = lk_hit ? lk_e.target : 32'd0;
        pred_taken  = lk_hit && lk_e.ctr[1];
        next_pc     = pred_taken ? pred_target : if_pc + 32'd4;
    end

    sat_ctr2 u_sat (
        .ctr_i (btb_q[ex_idx].ctr),
        .inc_i (ex_taken),
        .ctr_o (ctr_step)
    );

    // EX-side mispredict detection and the entry to write back.
    always_comb begin
        up_e          = btb_q[ex_idx];
        up_hit        = up_e.valid && (up_e.tag == ex_tag);
        mispredict    = (ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_target != ex_pred_target));
        ex_mispredict = ready && ex_valid && mispredict;
        redirect_pc   = ex_taken ? ex_target : ex_pc + 32'd4;
        // A not-taken branch that misses is not worth a slot.
        up_we         = ready && ex_valid && (up_hit || ex_taken);
        up_new        = up_e;
        if (up_hit) begin
            up_new.ctr = ctr_step;
            if (ex_taken) up_new.target = ex_target;
        end else begin
            up_new.valid  = 1'b1;
            up_new.tag    = ex_tag;
            up_new.target = ex_target;
            up_new.ctr    = CTR_WT;
        end
    end

    // Walk through every entry once, then serve predictions.
    always_comb begin
        state_d     = state_q;
        clear_idx_d = clear_idx_q;
        if (state_q == PRED_INIT) begin
            clear_idx_d = clear_idx_q + 1'b1;
            if (clear_idx_q == IDX_BITS'(ENTRIES - 1)) state_d = PRED_READY;
        end
    end

    // FSM, walk index and perf counter; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PRED_INIT;
            clear_idx_q <= '0;
            mp_cnt_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            clear_idx_q <= clear_idx_d;
            if (ex_mispredict) mp_cnt_q <= mp_cnt_q + 32'd1;
        end
    end

    // Table writes: one clear per cycle during the walk, else the EX update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == PRED_INIT) begin
                btb_q[clear_idx_q] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: CTR_WNT};
            end else if (up_we) begin
                btb_q[ex_idx] <= up_new;
            end
        end
    end

    // Tag and index must together cover the word address exactly.
    always_ff @(posedge clk) begin
        assert (TAG_BITS + IDX_BITS + 2 == 32);
    end

    assign init_busy      = (state_q == PRED_INIT);
    assign mispredict_cnt = mp_cnt_q;

endmodule
